// File: rtl/pc_stack_pkg.sv
// Shared constants and helpers for the sequencer program counter and its return stack.
package pc_stack_pkg;

    localparam int PC_ADDR_W_DEFAULT      = 12;
    localparam int PC_STACK_DEPTH_DEFAULT = 4;

    localparam logic [2:0] CMD_HOLD = 3'd0;
    localparam logic [2:0] CMD_INC  = 3'd1;
    localparam logic [2:0] CMD_LOAD = 3'd2;
    localparam logic [2:0] CMD_CALL = 3'd3;
    localparam logic [2:0] CMD_RET  = 3'd4;

    // Bits needed to hold values 0..v-1.
    function automatic int clog2(input int v);
        int r;
        int x;
        r = 0;
        x = v - 1;
        while (x > 0) begin
            r = r + 1;
            x = x >> 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/pc_call_stack_if.sv
// Command/status bundle between the decode unit (master) and the program counter (slave).
interface pc_call_stack_if
    import pc_stack_pkg::*;
#(
    parameter int ADDR_W      = PC_ADDR_W_DEFAULT,
    parameter int STACK_DEPTH = PC_STACK_DEPTH_DEFAULT
) ();
    localparam int LVL_W = clog2(STACK_DEPTH + 1);

    logic              enable;
    logic              load;
    logic [ADDR_W-1:0] load_value;
    logic              call;
    logic [ADDR_W-1:0] call_target;
    logic              ret;
    logic              err_clr;
    logic [ADDR_W-1:0] pc;
    logic [LVL_W-1:0]  stack_level;
    logic              stack_full;
    logic              stack_empty;
    logic              ovf_err;
    logic              unf_err;

    modport master (
        output enable, load, load_value, call, call_target, ret, err_clr,
        input  pc, stack_level, stack_full, stack_empty, ovf_err, unf_err
    );

    modport slave (
        input  enable, load, load_value, call, call_target, ret, err_clr,
        output pc, stack_level, stack_full, stack_empty, ovf_err, unf_err
    );

endinterface

// File: rtl/lifo_stack.sv
// Return-address LIFO. With PC_STACK_CIRCULAR_EN defined, a push while full
// overwrites the oldest entry via a circular write pointer.
module lifo_stack
    import pc_stack_pkg::*;
#(
    parameter  int WIDTH = PC_ADDR_W_DEFAULT,
    parameter  int DEPTH = PC_STACK_DEPTH_DEFAULT,
    localparam int LVL_W = clog2(DEPTH + 1),
    localparam int IDX_W = clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic [LVL_W-1:0] level,
    output logic             full,
    output logic             empty
);
    localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [LVL_W-1:0] level_q;
    logic [IDX_W-1:0] wr_idx;
    logic [IDX_W-1:0] top_idx;
    logic             do_push;
    logic             do_pop;

    assign full  = (level_q == FULL_LVL);
    assign empty = (level_q == '0);
    assign level = level_q;
    assign do_pop = pop && !empty;

`ifdef PC_STACK_CIRCULAR_EN
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);
    logic [IDX_W-1:0] wptr_q;

    assign do_push = push;
    assign wr_idx  = wptr_q;
    assign top_idx = (wptr_q == '0) ? LAST_IDX : wptr_q - 1'b1;

    always_ff @(posedge clk) begin
        if (reset) begin
            wptr_q <= '0;
        end else if (do_push) begin
            wptr_q <= (wptr_q == LAST_IDX) ? '0 : wptr_q + 1'b1;
        end else if (do_pop) begin
            wptr_q <= top_idx;
        end
    end
`else
    assign do_push = push && !full;
    assign wr_idx  = IDX_W'(level_q);
    assign top_idx = IDX_W'(level_q - 1'b1);
`endif

    assign dout = mem[top_idx];

    always_ff @(posedge clk) begin
        if (reset) begin
            level_q <= '0;
        end else if (do_push && !full) begin
            level_q <= level_q + 1'b1;
        end else if (do_pop) begin
            level_q <= level_q - 1'b1;
        end
    end

    // Contents are don't-care after reset, so storage carries no reset.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_idx] <= din;
        end
    end

endmodule

// File: rtl/pc_call_stack.sv
// Sequencer program counter with call/return stack and sticky overflow/underflow flags.
// Optional circular stack behaviour is selected by the PC_STACK_CIRCULAR_EN macro.
module pc_call_stack
    import pc_stack_pkg::*;
#(
    parameter int ADDR_W      = PC_ADDR_W_DEFAULT,
    parameter int STACK_DEPTH = PC_STACK_DEPTH_DEFAULT
) (
    input logic             clk,
    input logic             reset,
    pc_call_stack_if.slave  bus
);
    localparam int LVL_W = clog2(STACK_DEPTH + 1);

    logic [2:0]        cmd;
    logic [ADDR_W-1:0] pc_q;
    logic [ADDR_W-1:0] pc_nxt;
    logic [ADDR_W-1:0] pc_inc;
    logic [ADDR_W-1:0] ret_addr;
    logic [LVL_W-1:0]  level;
    logic              full;
    logic              empty;
    logic              push;
    logic              pop;
    logic              ovf_set;
    logic              unf_set;
    logic              ovf_q;
    logic              unf_q;

    assign pc_inc = pc_q + 1'b1;

    always_comb begin
        cmd = CMD_HOLD;
        if (bus.load) begin
            cmd = CMD_LOAD;
        end else if (bus.call) begin
            cmd = CMD_CALL;
        end else if (bus.ret) begin
            cmd = CMD_RET;
        end else if (bus.enable) begin
            cmd = CMD_INC;
        end
    end

`ifdef PC_STACK_CIRCULAR_EN
    assign push    = (cmd == CMD_CALL);
    assign ovf_set = 1'b0;
`else
    assign push    = (cmd == CMD_CALL) && !full;
    assign ovf_set = (cmd == CMD_CALL) && full;
`endif
    assign pop     = (cmd == CMD_RET) && !empty;
    assign unf_set = (cmd == CMD_RET) && empty;

    always_comb begin
        pc_nxt = pc_q;
        case (cmd)
            CMD_LOAD: pc_nxt = bus.load_value;
            CMD_CALL: if (push) pc_nxt = bus.call_target;
            CMD_RET:  if (pop)  pc_nxt = ret_addr;
            CMD_INC:  pc_nxt = pc_inc;
            default:  pc_nxt = pc_q;
        endcase
    end

    lifo_stack #(
        .WIDTH (ADDR_W),
        .DEPTH (STACK_DEPTH)
    ) u_stack (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .din   (pc_inc),
        .dout  (ret_addr),
        .level (level),
        .full  (full),
        .empty (empty)
    );

    // A new error in the same cycle as err_clr keeps its flag set.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q  <= '0;
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else begin
            pc_q  <= pc_nxt;
            ovf_q <= ovf_set | (ovf_q & ~bus.err_clr);
            unf_q <= unf_set | (unf_q & ~bus.err_clr);
        end
    end

    assign bus.pc          = pc_q;
    assign bus.stack_level = level;
    assign bus.stack_full  = full;
    assign bus.stack_empty = empty;
    assign bus.ovf_err     = ovf_q;
    assign bus.unf_err     = unf_q;

endmodule

// File: tb/tb_pc_call_stack.sv
// Self-checking bench for pc_call_stack: directed scenarios plus random commands
// checked against a queue-based reference model.
module tb_pc_call_stack;
    localparam int AW    = 12;
    localparam int DEPTH = 4;
    localparam int MOD   = 1 << AW;

    logic clk;
    logic reset;
    int   total;
    int   bad;

    int   mpc;
    int   mq[$];
    bit   movf;
    bit   munf;

    pc_call_stack_if #(.ADDR_W(AW), .STACK_DEPTH(DEPTH)) bus ();

    pc_call_stack #(.ADDR_W(AW), .STACK_DEPTH(DEPTH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void model_update(bit rs, bit en, bit ld, int lv, bit cl, int ct, bit rt, bit ec);
        if (rs) begin
            mpc = 0;
            mq.delete();
            movf = 0;
            munf = 0;
            return;
        end
        if (ec) begin
            movf = 0;
            munf = 0;
        end
        if (ld) begin
            mpc = lv;
        end else if (cl) begin
            if (mq.size() < DEPTH) begin
                mq.push_back((mpc + 1) % MOD);
                mpc = ct;
            end else begin
`ifdef PC_STACK_CIRCULAR_EN
                void'(mq.pop_front());
                mq.push_back((mpc + 1) % MOD);
                mpc = ct;
`else
                movf = 1;
`endif
            end
        end else if (rt) begin
            if (mq.size() > 0) mpc = mq.pop_back();
            else munf = 1;
        end else if (en) begin
            mpc = (mpc + 1) % MOD;
        end
    endfunction

    // Apply one cycle of commands, advance the model, sample 1 time unit after the edge.
    task automatic drive(bit rs, bit en, bit ld, int lv, bit cl, int ct, bit rt, bit ec);
        reset           = rs;
        bus.enable      = en;
        bus.load        = ld;
        bus.load_value  = lv[AW-1:0];
        bus.call        = cl;
        bus.call_target = ct[AW-1:0];
        bus.ret         = rt;
        bus.err_clr     = ec;
        model_update(rs, en, ld, lv, cl, ct, rt, ec);
        @(posedge clk);
        #1;
        reset = 0; bus.enable = 0; bus.load = 0; bus.call = 0; bus.ret = 0; bus.err_clr = 0;
    endtask

    task automatic test_reset();
        drive(1, 0, 0, 0, 0, 0, 0, 0);
        total++;
        if ({bus.pc, bus.stack_level, bus.ovf_err, bus.unf_err, bus.stack_empty} !== {12'h000, 3'd0, 1'b0, 1'b0, 1'b1}) begin
            bad++;
            $display("FAIL reset_state: pc=%h lvl=%0d ovf=%b unf=%b empty=%b want pc=000 lvl=0 flags=0 empty=1",
                     bus.pc, bus.stack_level, bus.ovf_err, bus.unf_err, bus.stack_empty);
        end
        for (int i = 0; i < 3; i++) drive(0, 1, 0, 0, 0, 0, 0, 0);
        total++;
        if ({bus.pc, bus.stack_level, bus.ovf_err, bus.unf_err} !== {12'h003, 3'd0, 1'b0, 1'b0}) begin
            bad++;
            $display("FAIL enable_x3: pc=%h lvl=%0d ovf=%b unf=%b want pc=003 lvl=0 flags=0",
                     bus.pc, bus.stack_level, bus.ovf_err, bus.unf_err);
        end
    endtask

    task automatic test_wrap();
        drive(0, 0, 1, 'hFFE, 0, 0, 0, 0);
        drive(0, 1, 0, 0, 0, 0, 0, 0);
        total++;
        if (bus.pc !== 12'hFFF) begin
            bad++;
            $display("FAIL wrap_fff: pc=%h want FFF", bus.pc);
        end
        drive(0, 1, 0, 0, 0, 0, 0, 0);
        total++;
        if ({bus.pc, bus.ovf_err, bus.unf_err} !== {12'h000, 1'b0, 1'b0}) begin
            bad++;
            $display("FAIL wrap_000: pc=%h ovf=%b unf=%b want pc=000 flags=0", bus.pc, bus.ovf_err, bus.unf_err);
        end
    endtask

    task automatic test_call_ret();
        drive(0, 0, 1, 'h010, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 1, 'h200, 0, 0);
        total++;
        if ({bus.pc, bus.stack_level} !== {12'h200, 3'd1}) begin
            bad++;
            $display("FAIL call: pc=%h lvl=%0d want pc=200 lvl=1", bus.pc, bus.stack_level);
        end
        drive(0, 0, 0, 0, 0, 0, 1, 0);
        total++;
        if ({bus.pc, bus.stack_level} !== {12'h011, 3'd0}) begin
            bad++;
            $display("FAIL ret: pc=%h lvl=%0d want pc=011 lvl=0", bus.pc, bus.stack_level);
        end
    endtask

    task automatic test_overflow();
        logic [AW-1:0] exp_ret [4];
        drive(0, 0, 1, 'h100, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) drive(0, 0, 0, 0, 1, 'h400 + 16 * i, 0, 0);
        total++;
        if ({bus.pc, bus.stack_level, bus.stack_full} !== {12'h430, 3'd4, 1'b1}) begin
            bad++;
            $display("FAIL nest4: pc=%h lvl=%0d full=%b want pc=430 lvl=4 full=1", bus.pc, bus.stack_level, bus.stack_full);
        end
        drive(0, 0, 0, 0, 1, 'h300, 0, 0);
`ifdef PC_STACK_CIRCULAR_EN
        total++;
        if ({bus.pc, bus.stack_level, bus.ovf_err} !== {12'h300, 3'd4, 1'b0}) begin
            bad++;
            $display("FAIL call_full: pc=%h lvl=%0d ovf=%b want pc=300 lvl=4 ovf=0", bus.pc, bus.stack_level, bus.ovf_err);
        end
        exp_ret[0] = 12'h431; exp_ret[1] = 12'h421; exp_ret[2] = 12'h411; exp_ret[3] = 12'h401;
`else
        total++;
        if ({bus.pc, bus.stack_level, bus.ovf_err} !== {12'h430, 3'd4, 1'b1}) begin
            bad++;
            $display("FAIL call_full: pc=%h lvl=%0d ovf=%b want pc=430 lvl=4 ovf=1", bus.pc, bus.stack_level, bus.ovf_err);
        end
        exp_ret[0] = 12'h421; exp_ret[1] = 12'h411; exp_ret[2] = 12'h401; exp_ret[3] = 12'h101;
`endif
        for (int i = 0; i < 4; i++) begin
            drive(0, 0, 0, 0, 0, 0, 1, 0);
            total++;
            if ({bus.pc, bus.stack_level} !== {exp_ret[i], 3'(3 - i)}) begin
                bad++;
                $display("FAIL ret_chain%0d: pc=%h lvl=%0d want pc=%h lvl=%0d", i, bus.pc, bus.stack_level, exp_ret[i], 3 - i);
            end
        end
    endtask

    task automatic test_priority_errors();
        drive(0, 0, 0, 0, 0, 0, 0, 1);
        drive(0, 1, 1, 'h055, 1, 'h123, 1, 0);
        total++;
        if ({bus.pc, bus.stack_level, bus.ovf_err, bus.unf_err} !== {12'h055, 3'd0, 1'b0, 1'b0}) begin
            bad++;
            $display("FAIL priority_load: pc=%h lvl=%0d ovf=%b unf=%b want pc=055 lvl=0 flags=0",
                     bus.pc, bus.stack_level, bus.ovf_err, bus.unf_err);
        end
        drive(0, 0, 0, 0, 0, 0, 1, 0);
        total++;
        if ({bus.pc, bus.unf_err} !== {12'h055, 1'b1}) begin
            bad++;
            $display("FAIL ret_empty: pc=%h unf=%b want pc=055 unf=1", bus.pc, bus.unf_err);
        end
        drive(0, 0, 0, 0, 0, 0, 0, 1);
        total++;
        if (bus.unf_err !== 1'b0) begin
            bad++;
            $display("FAIL err_clr: unf=%b want 0", bus.unf_err);
        end
        drive(0, 0, 0, 0, 0, 0, 1, 1);
        total++;
        if (bus.unf_err !== 1'b1) begin
            bad++;
            $display("FAIL set_wins: unf=%b want 1", bus.unf_err);
        end
    endtask

    task automatic test_reset_override();
        drive(0, 0, 0, 0, 1, 'h050, 0, 0);
        drive(0, 0, 0, 0, 1, 'h060, 0, 0);
        drive(0, 0, 0, 0, 0, 0, 1, 0);
        drive(0, 0, 0, 0, 1, 'h070, 0, 0);
        total++;
        if ({bus.pc, bus.stack_level} !== {12'h070, 3'd2}) begin
            bad++;
            $display("FAIL pre_reset: pc=%h lvl=%0d want pc=070 lvl=2", bus.pc, bus.stack_level);
        end
        drive(1, 0, 0, 0, 1, 'h080, 0, 0);
        total++;
        if ({bus.pc, bus.stack_level, bus.ovf_err, bus.unf_err} !== {12'h000, 3'd0, 1'b0, 1'b0}) begin
            bad++;
            $display("FAIL reset_override: pc=%h lvl=%0d ovf=%b unf=%b want pc=000 lvl=0 flags=0",
                     bus.pc, bus.stack_level, bus.ovf_err, bus.unf_err);
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 600; n++) begin
            bit rs, en, ld, cl, rt, ec;
            rs = ($urandom_range(0, 99) < 2);
            en = ($urandom_range(0, 99) < 50);
            ld = ($urandom_range(0, 99) < 8);
            cl = ($urandom_range(0, 99) < 30);
            rt = ($urandom_range(0, 99) < 30);
            ec = ($urandom_range(0, 99) < 10);
            drive(rs, en, ld, int'($urandom_range(0, MOD - 1)), cl, int'($urandom_range(0, MOD - 1)), rt, ec);
            total++;
            if ({bus.pc, bus.stack_level, bus.ovf_err, bus.unf_err} !==
                {12'(mpc), 3'(mq.size()), movf, munf}) begin
                bad++;
                $display("FAIL random%0d: pc=%h lvl=%0d ovf=%b unf=%b want pc=%h lvl=%0d ovf=%b unf=%b",
                         n, bus.pc, bus.stack_level, bus.ovf_err, bus.unf_err, 12'(mpc), mq.size(), movf, munf);
            end
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        mpc   = 0;
        movf  = 0;
        munf  = 0;
        reset = 1;
        bus.enable = 0; bus.load = 0; bus.load_value = '0; bus.call = 0;
        bus.call_target = '0; bus.ret = 0; bus.err_clr = 0;
        @(negedge clk);
        test_reset();
        test_wrap();
        test_call_ret();
        test_overflow();
        test_priority_errors();
        test_reset_override();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
